// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and the separate I-memory.
interface fetch_stage_if #(
  parameter int unsigned Instr_width = 32,
  parameter int unsigned PC_width    = 32
);
  logic [PC_width-1:0]    ImemAddr;
  logic                   ImemReq;
  logic                   ImemAck;
  logic [Instr_width-1:0] ImemRdata;

  modport master (
    output ImemAddr,
    output ImemReq,
    input  ImemAck,
    input  ImemRdata
  );

  modport slave (
    input  ImemAddr,
    input  ImemReq,
    output ImemAck,
    output ImemRdata
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS fetch stage with IF/ID register, redirect handling and a one-entry hold buffer.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_stage #(
  parameter int unsigned        Instr_width = 32,
  parameter int unsigned        PC_width    = 32,
  parameter logic [PC_width-1:0] RESET_PC   = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   StallD,
  input  logic [1:0]             PCSrcD,
  input  logic [PC_width-1:0]    PCBranchD,
  input  logic [PC_width-1:0]    PCJumpD,
  fetch_stage_if.master          imem,
  output logic [Instr_width-1:0] InstrD,
  output logic [PC_width-1:0]    PCPlus4D,
  output logic                   ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            FetchCnt,
  output logic [31:0]            FlushCnt
`endif
);

  typedef enum logic [1:0] {StBoot, StReq, StHold, StDiscard} state_e;

  state_e                 state_q, state_d;
  logic [PC_width-1:0]    pcf_q, pcf_d;
  logic [PC_width-1:0]    redir_q, redir_d;
  logic                   req_q, req_d;
  logic                   hold_full_q, hold_full_d;
  logic [Instr_width-1:0] hold_instr_q, hold_instr_d;
  logic [PC_width-1:0]    hold_pc4_q, hold_pc4_d;
  logic [Instr_width-1:0] instr_q, instr_d;
  logic [PC_width-1:0]    pc4_q, pc4_d;
  logic                   valid_q, valid_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]            fetch_cnt_q, fetch_cnt_d;
  logic [31:0]            flush_cnt_q, flush_cnt_d;
`endif

  logic                redirect;
  logic                accept;
  logic [PC_width-1:0] target;
  logic [PC_width-1:0] pcf_plus4;

  always_comb begin
    // PCSrcD is only meaningful when decode is not stalled.
    redirect  = (PCSrcD != 2'b00) && !StallD;
    target    = PCSrcD[1] ? PCJumpD : PCBranchD;
    pcf_plus4 = pcf_q + PC_width'(4);
    accept    = (state_q == StReq) && imem.ImemAck && !redirect;

    state_d      = state_q;
    pcf_d        = pcf_q;
    redir_d      = redir_q;
    hold_full_d  = hold_full_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;

    unique case (state_q)
      StBoot: begin
        state_d = StReq;
        if (redirect) pcf_d = target;
      end
      StReq: begin
        if (redirect) begin
          if (imem.ImemAck) begin
            pcf_d = target;
          end else begin
            // Request cannot be withdrawn; wait out its ack before fetching the target.
            redir_d = target;
            state_d = StDiscard;
          end
        end else if (imem.ImemAck) begin
          pcf_d = pcf_plus4;
          if (StallD) begin
            hold_full_d  = 1'b1;
            hold_instr_d = imem.ImemRdata;
            hold_pc4_d   = pcf_plus4;
            state_d      = StHold;
          end
        end
      end
      StHold: begin
        if (redirect) begin
          pcf_d   = target;
          state_d = StReq;
        end else if (!StallD) begin
          state_d = StReq;
        end
      end
      StDiscard: begin
        if (redirect) begin
          redir_d = target;
          if (imem.ImemAck) begin
            pcf_d   = target;
            state_d = StReq;
          end
        end else if (imem.ImemAck) begin
          pcf_d   = redir_q;
          state_d = StReq;
        end
      end
      default: state_d = StBoot;
    endcase

    if (redirect) hold_full_d = 1'b0;

    if (!StallD) begin
      if (redirect) begin
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
      end else if (hold_full_q) begin
        instr_d     = hold_instr_q;
        pc4_d       = hold_pc4_q;
        valid_d     = 1'b1;
        hold_full_d = 1'b0;
      end else if (accept) begin
        instr_d = imem.ImemRdata;
        pc4_d   = pcf_plus4;
        valid_d = 1'b1;
      end else begin
        // Bubble keeps the last PCPlus4D.
        instr_d = '0;
        valid_d = 1'b0;
      end
    end

    req_d = (state_d == StReq) || (state_d == StDiscard);

`ifdef FETCH_PERF_CNT_EN
    fetch_cnt_d = fetch_cnt_q + (accept ? 32'd1 : 32'd0);
    flush_cnt_d = flush_cnt_q + (redirect ? 32'd1 : 32'd0);
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StBoot;
      pcf_q        <= RESET_PC;
      redir_q      <= RESET_PC;
      req_q        <= 1'b0;
      hold_full_q  <= 1'b0;
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
      instr_q      <= '0;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
      fetch_cnt_q  <= '0;
      flush_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      redir_q      <= redir_d;
      req_q        <= req_d;
      hold_full_q  <= hold_full_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
`ifdef FETCH_PERF_CNT_EN
      fetch_cnt_q  <= fetch_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
`endif
    end
  end

  // The address register is PCF itself; in DISCARD it still holds the abandoned address.
  assign imem.ImemAddr = pcf_q;
  assign imem.ImemReq  = req_q;
  assign InstrD        = instr_q;
  assign PCPlus4D      = pc4_q;
  assign ValidD        = valid_q;
`ifdef FETCH_PERF_CNT_EN
  assign FetchCnt      = fetch_cnt_q;
  assign FlushCnt      = flush_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the pipelined 32-bit MIPS (Harvard) core; directly upstream of the decode stage.
- Owns PCF and the req/ack handshake to the separate instruction memory.
- Applies redirects from decode (PCSrcD, PCBranchD, PCJumpD) and delivers InstrD, PCPlus4D and ValidD to decode.
- One-entry hold buffer absorbs an instruction returned while decode is stalled.

Parameters:
- Instr_width, 32, instruction width.
- PC_width, 32, PC and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- StallD  in  1  hazard-unit stall; freezes IF/ID and PC advance.
- PCSrcD  in  2  {JumpD, BranchD&EqualD}; any set bit = redirect.
- PCBranchD  in  PC_width  branch target.
- PCJumpD  in  PC_width  jump target.
- ImemAddr  out  PC_width  fetch address.
- ImemReq  out  1  fetch request.
- ImemAck  in  1  memory response; ImemRdata valid in the same cycle.
- ImemRdata  in  Instr_width  fetched instruction.
- InstrD  out  Instr_width  IF/ID instruction.
- PCPlus4D  out  PC_width  IF/ID PC+4.
- ValidD  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (RST=0, async) values:
  - PCF=RESET_PC; state=BOOT; hold buffer empty.
  - InstrD=0, PCPlus4D=0, ValidD=0.
  - ImemReq=0; ImemAddr=RESET_PC.
- States: BOOT, REQ, HOLD, DISCARD.
  - BOOT: ImemReq=0; next cycle -> REQ.
  - REQ: ImemReq=1, ImemAddr=PCF. Address stays stable until ack; the request is never withdrawn.
  - HOLD: ImemReq=0. The hold buffer contains {instr, PCF_old+4}.
  - DISCARD: ImemReq=1, ImemAddr=old PCF. Waits for ImemAck, drops the data, then loads PCF from RedirPC and goes to REQ.
- Redirect is recognised only when PCSrcD!=0 and StallD=0; PCSrcD is ignored while StallD=1.
- Redirect target:
  - PCSrcD[1]=1 -> PCJumpD (jump has priority).
  - PCSrcD=01 -> PCBranchD.
- Accept = state REQ & ImemAck & no redirect.
  - On accept: PCF<=PCF+4 (mod 2^PC_width, wraps silently).
  - Fetched pair = {ImemRdata, PCF+4}.
- IF/ID update when StallD=0, in priority order:
  1. Redirect -> flush: InstrD<=0, ValidD<=0, PCPlus4D<=0.
  2. Hold buffer full -> load hold contents, ValidD<=1, hold empties; state HOLD->REQ.
  3. Accept this cycle -> load fetched pair, ValidD<=1; stay REQ.
  4. Otherwise -> bubble: ValidD<=0, InstrD<=0. PCPlus4D holds.
- StallD=1: IF/ID unchanged. An accept this cycle writes the hold buffer; state -> HOLD.
- Redirect handling:
  - Hold buffer empties.
  - In REQ with no ack: RedirPC<=target; state -> DISCARD.
  - In REQ with ack, or in HOLD: PCF<=target; state -> REQ (the acked instruction is dropped).
  - In DISCARD: RedirPC is overwritten by the newer target.
  - DISCARD with ack in the same cycle as a new redirect: PCF<=new target; state -> REQ.
- Latency: with zero wait states, an instruction reaches IF/ID one cycle after its request cycle. Throughput is 1/cycle.
- Reset mid-request: state returns to BOOT. A late ImemAck in BOOT is ignored; memory must tolerate request abandonment on reset.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs FetchCnt[31:0] and FlushCnt[31:0], both reset to 0.
  - FetchCnt increments on each accept.
  - FlushCnt increments on each recognised redirect.
  - Both wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, ImemAck=1 every cycle, Rdata=addr:
  - Cycle 1 after release: ImemReq=1, ImemAddr=0.
  - ValidD=1 with InstrD=0x0, then 0x4, 0x8.
  - PCPlus4D=0x4, 0x8, 0xC.
- Two-cycle wait states at addr 0x8 -> ImemAddr holds 0x8 for 3 cycles; ValidD=0 for 2 cycles; then InstrD=0x8.
- StallD=1 for 3 cycles while ack for 0x10 arrives:
  - IF/ID frozen; ImemReq=0 in HOLD.
  - On StallD=0: InstrD=0x10, PCPlus4D=0x14; next ImemAddr=0x14.
- PCSrcD=01, PCBranchD=0x100 while 0x20 is outstanding without ack:
  - ValidD=0 next cycle; DISCARD drops the 0x20 data.
  - Then ImemAddr=0x100; InstrD=0x100 delivered.
- PCSrcD=11, PCJumpD=0x400, PCBranchD=0x200 with ack same cycle -> next ImemAddr=0x400; flushed slot ValidD=0.
- PCSrcD=10 while StallD=1 -> ignored; PCF continues sequentially.
- Assert RST low mid-REQ at 0x30 -> outputs go to reset values immediately; fetch restarts at RESET_PC.
